// File: rtl/store_narrow_if.sv
// -----------------------------------------------------------------------------
// store_narrow_if
// Bundles the store-request handshake and the byte-wide data-memory write port
// of the store narrowing unit.
//
// Signals (named from the unit's point of view):
//   req_valid_i    store request valid
//   req_ready_o    unit can accept a request
//   addr_i         byte address of the store (ADDR_W bits)
//   data_i         32-bit register value to store
//   size_i         store width: 00 byte, 01 half, 10 word, 11 illegal
//   signed_ctrl_i  truncation check mode: 1 signed, 0 unsigned
//   mem_we_o       byte write strobe
//   mem_addr_o     byte write address (ADDR_W bits)
//   mem_data_o     byte write data
//   mem_ready_i    memory accepts the presented byte this cycle
//   done_o         one-cycle completion pulse
//   err_o          request rejected, valid with done_o
//   trunc_o        upper bits lost in truncation, valid with done_o
//
// Modports:
//   slave  - the store_narrow unit
//   master - the requester / memory side (MEM stage, testbench)
// -----------------------------------------------------------------------------
interface store_narrow_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       data_i;
  logic [1:0]        size_i;
  logic              signed_ctrl_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_data_o;
  logic              mem_ready_i;
  logic              done_o;
  logic              err_o;
  logic              trunc_o;

  modport slave (
    input  req_valid_i, addr_i, data_i, size_i, signed_ctrl_i, mem_ready_i,
    output req_ready_o, mem_we_o, mem_addr_o, mem_data_o, done_o, err_o, trunc_o
  );

  modport master (
    output req_valid_i, addr_i, data_i, size_i, signed_ctrl_i, mem_ready_i,
    input  req_ready_o, mem_we_o, mem_addr_o, mem_data_o, done_o, err_o, trunc_o
  );
endinterface

// File: rtl/store_narrow.sv
// -----------------------------------------------------------------------------
// store_narrow
// Store-path narrowing unit. Accepts a 32-bit store request, truncates it to
// byte / halfword / word width and writes it little-endian, one byte per
// accepted memory cycle, onto a byte-wide write port. Flags misaligned or
// illegal-size requests (no bytes written) and stores whose upper bits are not
// a pure sign/zero extension of the stored width (bytes still written).
//
// Ports:
//   clk_i   rising-edge clock
//   rst_i   asynchronous, active-low reset
//   bus     store_narrow_if.slave: request handshake, memory write port and
//           completion flags (see store_narrow_if for the signal list)
//
// All outputs come straight from flops; the next-state logic computes both the
// FSM state and the values the outputs must show in the following cycle, so no
// request or mem_ready input reaches an output combinationally.
// -----------------------------------------------------------------------------
module store_narrow #(
  parameter int ADDR_W = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  store_narrow_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Index of the final byte to write for a given store size.
  function automatic logic [1:0] last_index(input logic [1:0] size);
    logic [1:0] idx;
    case (size)
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      2'b10:   idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Illegal size or natural-alignment violation.
  function automatic logic size_error(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Upper bits are not a pure sign (signed) or zero (unsigned) extension of
  // the stored width. Word stores keep every bit, so they never truncate.
  function automatic logic trunc_check(input logic [31:0] data,
                                       input logic [1:0]  size,
                                       input logic        sgn);
    logic lost;
    case (size)
      2'b00: begin
        if (sgn) begin
          lost = (data[31:8] != {24{data[7]}});
        end else begin
          lost = (data[31:8] != 24'h00_0000);
        end
      end
      2'b01: begin
        if (sgn) begin
          lost = (data[31:16] != {16{data[15]}});
        end else begin
          lost = (data[31:16] != 16'h0000);
        end
      end
      default: lost = 1'b0;
    endcase
    return lost;
  endfunction

  // Little-endian byte lane selection.
  function automatic logic [7:0] select_byte(input logic [31:0] data,
                                             input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      2'd3:    b = data[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q,  state_d;
  logic [1:0]        idx_q,    idx_d;
  logic [1:0]        last_q,   last_d;
  logic [ADDR_W-1:0] base_q,   base_d;
  logic [31:0]       data_q,   data_d;
  logic              err_q,    err_d;
  logic              trunc_q,  trunc_d;

  // Output flops
  logic              ready_q,    ready_d;
  logic              we_q,       we_d;
  logic [ADDR_W-1:0] maddr_q,    maddr_d;
  logic [7:0]        mdata_q,    mdata_d;
  logic              done_q,     done_d;
  logic              err_out_q,  err_out_d;
  logic              trunc_out_q, trunc_out_d;

  logic accept_s;
  logic req_err_s;
  logic req_trunc_s;

  assign accept_s    = bus.req_valid_i && ready_q;
  assign req_err_s   = size_error(bus.size_i, bus.addr_i[1:0]);
  assign req_trunc_s = trunc_check(bus.data_i, bus.size_i, bus.signed_ctrl_i);

  // Next-state logic and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    base_d      = base_q;
    data_d      = data_q;
    err_d       = err_q;
    trunc_d     = trunc_q;
    ready_d     = 1'b0;
    we_d        = 1'b0;
    maddr_d     = {ADDR_W{1'b0}};
    mdata_d     = 8'h00;
    done_d      = 1'b0;
    err_out_d   = 1'b0;
    trunc_out_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          ready_d = 1'b0;
          base_d  = bus.addr_i;
          data_d  = bus.data_i;
          idx_d   = 2'd0;
          last_d  = last_index(bus.size_i);
          err_d   = req_err_s;
          // A rejected request writes nothing, so there is nothing to lose.
          trunc_d = req_err_s ? 1'b0 : req_trunc_s;
          state_d = req_err_s ? ST_RESP : ST_WRITE;
        end else begin
          // Also raises ready on the first edge after reset release.
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (bus.mem_ready_i) begin
          if (idx_q == last_q) begin
            state_d = ST_RESP;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
      end
    endcase

    // Outputs for the next cycle are derived from the next state, so the byte
    // being presented (and its address) stay put while mem_ready is low.
    if (state_d == ST_WRITE) begin
      we_d    = 1'b1;
      // base + idx wraps modulo 2^ADDR_W; carry out is discarded.
      maddr_d = base_d + {{(ADDR_W-2){1'b0}}, idx_d};
      mdata_d = select_byte(data_d, idx_d);
    end else begin
      we_d    = 1'b0;
      maddr_d = {ADDR_W{1'b0}};
      mdata_d = 8'h00;
    end

    if (state_d == ST_RESP) begin
      done_d      = 1'b1;
      err_out_d   = err_d;
      trunc_out_d = trunc_d;
    end else begin
      done_d      = 1'b0;
      err_out_d   = 1'b0;
      trunc_out_d = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      base_q      <= {ADDR_W{1'b0}};
      data_q      <= 32'h0000_0000;
      err_q       <= 1'b0;
      trunc_q     <= 1'b0;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      maddr_q     <= {ADDR_W{1'b0}};
      mdata_q     <= 8'h00;
      done_q      <= 1'b0;
      err_out_q   <= 1'b0;
      trunc_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      base_q      <= base_d;
      data_q      <= data_d;
      err_q       <= err_d;
      trunc_q     <= trunc_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      maddr_q     <= maddr_d;
      mdata_q     <= mdata_d;
      done_q      <= done_d;
      err_out_q   <= err_out_d;
      trunc_out_q <= trunc_out_d;
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = maddr_q;
  assign bus.mem_data_o  = mdata_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_out_q;
  assign bus.trunc_o     = trunc_out_q;

endmodule

// File: tb/tb_store_narrow.sv
// -----------------------------------------------------------------------------
// tb_store_narrow
// Directed testbench for store_narrow. A transaction-level model (queue of
// expected byte writes plus a pending response) predicts every output each
// cycle; directed checks pin latencies, written bytes and flags to literals.
// -----------------------------------------------------------------------------
module tb_store_narrow;

  localparam int ADDR_W = 32;

  logic clk   = 1'b0;
  logic rst_i = 1'b0;

  store_narrow_if #(.ADDR_W(ADDR_W)) bus ();

  store_narrow #(.ADDR_W(ADDR_W)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: what the outputs must be, from the store rules.
  // ---------------------------------------------------------------------------
  logic [39:0] m_writes[$];   // {addr, byte} still to be written, in order
  bit          m_busy    = 1'b0;
  bit          m_done    = 1'b0;   // current cycle is the completion cycle
  bit          m_ready   = 1'b0;
  bit          m_err     = 1'b0;
  bit          m_trunc   = 1'b0;

  function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
    int unsigned au = a;
    return (sz == 2'd3) || (sz == 2'd1 && (au % 2) != 0) || (sz == 2'd2 && (au % 4) != 0);
  endfunction

  // Value fits in the stored width as a signed/unsigned number?
  function automatic bit model_trunc(input logic [31:0] d, input logic [1:0] sz, input logic sg);
    longint v;
    if (sg) v = longint'($signed(d));
    else    v = longint'({32'h0, d});
    if (sz == 2'd0) return sg ? (v < -128 || v > 127) : (v > 255);
    if (sz == 2'd1) return sg ? (v < -32768 || v > 32767) : (v > 65535);
    return 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_i);
      if (!rst_i) begin
        m_writes.delete();
        m_busy = 0; m_done = 0; m_ready = 0; m_err = 0; m_trunc = 0;
      end else if (m_done) begin
        m_done = 0; m_busy = 0; m_ready = 1; m_err = 0; m_trunc = 0;
      end else if (!m_busy) begin
        if (m_ready && bus.req_valid_i) begin
          m_ready = 0;
          m_busy  = 1;
          m_err   = model_err(bus.addr_i, bus.size_i);
          m_trunc = m_err ? 1'b0 : model_trunc(bus.data_i, bus.size_i, bus.signed_ctrl_i);
          if (m_err) begin
            m_done = 1;
          end else begin
            for (int k = 0; k < (1 << bus.size_i); k++) begin
              logic [31:0] a;
              logic [31:0] sh;
              a  = bus.addr_i + 32'(k);
              sh = bus.data_i >> (8 * k);
              m_writes.push_back({a, sh[7:0]});
            end
          end
        end else begin
          m_ready = 1;
        end
      end else if (m_writes.size() > 0 && bus.mem_ready_i) begin
        void'(m_writes.pop_front());
        if (m_writes.size() == 0) m_done = 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_ready", 64'(bus.req_ready_o), 64'(m_ready));
    chk("cyc_we",    64'(bus.mem_we_o),    64'(m_writes.size() > 0));
    if (m_writes.size() > 0) begin
      chk("cyc_addr", 64'(bus.mem_addr_o), 64'(m_writes[0][39:8]));
      chk("cyc_data", 64'(bus.mem_data_o), 64'(m_writes[0][7:0]));
    end
    chk("cyc_done",  64'(bus.done_o),  64'(m_done));
    chk("cyc_err",   64'(bus.err_o),   64'(m_done ? m_err : 1'b0));
    chk("cyc_trunc", 64'(bus.trunc_o), 64'(m_done ? m_trunc : 1'b0));
  end

  // Log of bytes actually accepted by memory, and count of done pulses.
  logic [39:0] wlog[$];
  int          done_cnt = 0;

  always @(posedge clk) begin
    if (rst_i && bus.mem_we_o && bus.mem_ready_i) wlog.push_back({bus.mem_addr_o, bus.mem_data_o});
  end

  always @(negedge clk) begin
    if (bus.done_o) done_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_ready(input string nm);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready_o) ok = 1;
    end
    if (!ok) chk({nm, "_ready_timeout"}, 64'd0, 64'd1);
  endtask

  // Issue one request, drive mem_ready from pat (bit k-1 for cycle T+k),
  // and check done latency and flags.
  task automatic run_req(input string nm, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic sg, input logic [7:0] pat,
                         input int exp_lat, input logic exp_err, input logic exp_trunc);
    bit seen = 0;
    wlog.delete();
    wait_ready(nm);
    bus.addr_i = a; bus.data_i = d; bus.size_i = sz; bus.signed_ctrl_i = sg;
    bus.req_valid_i = 1'b1;
    @(posedge clk); #2;
    // Scramble the request lines so only captured values can be written.
    bus.req_valid_i = 1'b0;
    bus.addr_i = ~a; bus.data_i = ~d; bus.size_i = ~sz; bus.signed_ctrl_i = ~sg;
    for (int k = 1; k <= 20 && !seen; k++) begin
      bus.mem_ready_i = (k <= 8) ? pat[k-1] : 1'b1;
      @(negedge clk);
      if (bus.done_o) begin
        seen = 1;
        chk({nm, "_lat"},   64'(k),           64'(exp_lat));
        chk({nm, "_err"},   64'(bus.err_o),   64'(exp_err));
        chk({nm, "_trunc"}, 64'(bus.trunc_o), 64'(exp_trunc));
      end else begin
        @(posedge clk); #2;
      end
    end
    if (!seen) chk({nm, "_done_timeout"}, 64'd0, 64'd1);
    bus.mem_ready_i = 1'b1;
  endtask

  task automatic check_log(input string nm, input int n,
                           input logic [39:0] e0, input logic [39:0] e1,
                           input logic [39:0] e2, input logic [39:0] e3);
    logic [39:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({nm, "_nbytes"}, 64'(wlog.size()), 64'(n));
    for (int i = 0; i < n && i < wlog.size(); i++) chk({nm, "_byte"}, 64'(wlog[i]), 64'(e[i]));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int dc;
    bus.req_valid_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
    bus.size_i = 2'b00; bus.signed_ctrl_i = 1'b0; bus.mem_ready_i = 1'b1;

    // Reset release after three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_low", 64'(bus.req_ready_o), 64'd0);
    chk("rst_we_low",    64'(bus.mem_we_o),    64'd0);
    @(posedge clk); #2; rst_i = 1'b1;
    @(negedge clk);
    chk("rel_ready_before_edge", 64'(bus.req_ready_o), 64'd0);
    @(negedge clk);
    chk("rel_ready_after_edge",  64'(bus.req_ready_o), 64'd1);

    // Word store.
    run_req("word", 32'h0000_0100, 32'h1122_3344, 2'b10, 1'b0, 8'hFF, 5, 1'b0, 1'b0);
    check_log("word", 4, {32'h100, 8'h44}, {32'h101, 8'h33}, {32'h102, 8'h22}, {32'h103, 8'h11});

    // Signed half stores.
    run_req("half_s_ok", 32'h0000_0202, 32'hFFFF_8001, 2'b01, 1'b1, 8'hFF, 3, 1'b0, 1'b0);
    check_log("half_s_ok", 2, {32'h202, 8'h01}, {32'h203, 8'h80}, 40'h0, 40'h0);
    run_req("half_s_tr", 32'h0000_0202, 32'h0001_8001, 2'b01, 1'b1, 8'hFF, 3, 1'b0, 1'b1);
    check_log("half_s_tr", 2, {32'h202, 8'h01}, {32'h203, 8'h80}, 40'h0, 40'h0);

    // Byte stores of 0xFF.
    run_req("byte_u", 32'h0000_0050, 32'h0000_00FF, 2'b00, 1'b0, 8'hFF, 2, 1'b0, 1'b0);
    check_log("byte_u", 1, {32'h50, 8'hFF}, 40'h0, 40'h0, 40'h0);
    run_req("byte_s", 32'h0000_0051, 32'h0000_00FF, 2'b00, 1'b1, 8'hFF, 2, 1'b0, 1'b1);
    check_log("byte_s", 1, {32'h51, 8'hFF}, 40'h0, 40'h0, 40'h0);

    // Rejected requests.
    run_req("err_half", 32'h0000_0301, 32'h0000_1234, 2'b01, 1'b0, 8'hFF, 1, 1'b1, 1'b0);
    check_log("err_half", 0, 40'h0, 40'h0, 40'h0, 40'h0);
    run_req("err_word", 32'h0000_0302, 32'h1234_5678, 2'b10, 1'b0, 8'hFF, 1, 1'b1, 1'b0);
    check_log("err_word", 0, 40'h0, 40'h0, 40'h0, 40'h0);
    run_req("err_size", 32'h0000_0400, 32'hFFFF_FFFF, 2'b11, 1'b1, 8'hFF, 1, 1'b1, 1'b0);
    check_log("err_size", 0, 40'h0, 40'h0, 40'h0, 40'h0);

    // Backpressure: mem_ready 1,0,0,1,1,1.
    run_req("bp_word", 32'h0000_0500, 32'hA1B2_C3D4, 2'b10, 1'b0, 8'b1111_1001, 7, 1'b0, 1'b0);
    check_log("bp_word", 4, {32'h500, 8'hD4}, {32'h501, 8'hC3}, {32'h502, 8'hB2}, {32'h503, 8'hA1});

    // Reset during the third byte of a word store.
    wait_ready("rst_mid");
    dc = done_cnt;
    bus.addr_i = 32'h0000_0600; bus.data_i = 32'hCAFE_F00D; bus.size_i = 2'b10;
    bus.signed_ctrl_i = 1'b0; bus.req_valid_i = 1'b1; bus.mem_ready_i = 1'b1;
    @(posedge clk); #2; bus.req_valid_i = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("rst_mid_we_before", 64'(bus.mem_we_o),   64'd1);
    chk("rst_mid_addr_before", 64'(bus.mem_addr_o), 64'h602);
    rst_i = 1'b0;
    #1;
    chk("rst_mid_we",    64'(bus.mem_we_o),    64'd0);
    chk("rst_mid_addr",  64'(bus.mem_addr_o),  64'd0);
    chk("rst_mid_data",  64'(bus.mem_data_o),  64'd0);
    chk("rst_mid_done",  64'(bus.done_o),      64'd0);
    chk("rst_mid_ready", 64'(bus.req_ready_o), 64'd0);
    repeat (2) @(posedge clk);
    #2; rst_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_ready_after", 64'(bus.req_ready_o), 64'd1);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_done", 64'(done_cnt - dc), 64'd0);

    // Unit works again after the abort.
    run_req("post_rst", 32'h0000_0060, 32'h0000_007F, 2'b00, 1'b1, 8'hFF, 2, 1'b0, 1'b0);
    check_log("post_rst", 1, {32'h60, 8'h7F}, 40'h0, 40'h0, 40'h0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
